// File: rtl/phase_sequencer.sv
// phase_sequencer: steps the seconds timer through a fixed program of
// NUM_PHASES timed phases. Each phase loads its duration into the timer,
// waits for the timer's done pulse, then moves on. A zero duration skips
// its phase without touching the timer.
//
// Optional build macro PHASE_SEQ_PAUSE_EN adds a pause input and a
// tmr_hold output that freeze a phase while it is waiting on the timer.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | no program running; waits for start (without abort)
// LOAD  | fetch duration of the current phase; pulse tmr_load or skip
// WAIT  | timer running; waits for tmr_done (or pause release)
// NEXT  | advance phase index, or finish after the last phase
// DONE  | one-cycle cycle_done pulse, then back to IDLE
module phase_sequencer #(
    parameter int NUM_PHASES = 4,
    parameter int PW         = 2,
    parameter int TW         = 16
) (
    input  logic                     CLK,
    input  logic                     reset,
    input  logic                     start,
    input  logic                     abort,
    input  logic [NUM_PHASES*TW-1:0] phase_dur,
    input  logic                     tmr_done,
`ifdef PHASE_SEQ_PAUSE_EN
    input  logic                     pause,
    output logic                     tmr_hold,
`endif
    output logic                     tmr_load,
    output logic [TW-1:0]            tmr_secs,
    output logic                     tmr_clear,
    output logic [PW-1:0]            phase,
    output logic                     busy,
    output logic                     cycle_done
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_WAIT = 3'd2,
        S_NEXT = 3'd3,
        S_DONE = 3'd4
    } state_t;

    localparam logic [PW-1:0] LAST_PHASE = PW'(NUM_PHASES - 1);

    state_t          state_q;
    state_t          state_nxt;
    logic [PW-1:0]   phase_nxt;
    logic [TW-1:0]   secs_nxt;
    logic            load_nxt;
    logic            clear_nxt;
    logic            cdone_nxt;
    logic [TW-1:0]   cur_dur;
    logic            done_seen;
`ifdef PHASE_SEQ_PAUSE_EN
    logic            hold_nxt;
    logic            done_pend;
    logic            pend_nxt;
`endif

    // A done pulse that overlaps the load cycle belongs to the previous phase.
    assign done_seen = tmr_done && !tmr_load;

    // Moore decode of the state register.
    assign busy = (state_q != S_IDLE);

    // Select the duration slot addressed by the current phase index.
    always_comb begin
        cur_dur = '0;
        for (int i = 0; i < NUM_PHASES; i++) begin
            if (phase == PW'(i)) begin
                cur_dur = phase_dur[i*TW +: TW];
            end
        end
    end

    // Next-state and next-output decode; abort from any busy state wins.
    always_comb begin
        state_nxt = state_q;
        phase_nxt = phase;
        secs_nxt  = tmr_secs;
        load_nxt  = 1'b0;
        clear_nxt = 1'b0;
        cdone_nxt = 1'b0;
`ifdef PHASE_SEQ_PAUSE_EN
        hold_nxt  = 1'b0;
        pend_nxt  = 1'b0;
`endif
        if (abort && (state_q != S_IDLE)) begin
            state_nxt = S_IDLE;
            clear_nxt = 1'b1;
            phase_nxt = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start && !abort) begin
                        state_nxt = S_LOAD;
                        phase_nxt = '0;
                    end
                end
                S_LOAD: begin
                    if (cur_dur != '0) begin
                        secs_nxt  = cur_dur;
                        load_nxt  = 1'b1;
                        state_nxt = S_WAIT;
                    end else begin
                        state_nxt = S_NEXT;
                    end
                end
                S_WAIT: begin
`ifdef PHASE_SEQ_PAUSE_EN
                    if (pause) begin
                        hold_nxt = 1'b1;
                        pend_nxt = done_pend || done_seen;
                    end else if (done_seen || done_pend) begin
                        state_nxt = S_NEXT;
                    end
`else
                    if (done_seen) begin
                        state_nxt = S_NEXT;
                    end
`endif
                end
                S_NEXT: begin
                    if (phase == LAST_PHASE) begin
                        state_nxt = S_DONE;
                        cdone_nxt = 1'b1;
                    end else begin
                        phase_nxt = phase + PW'(1);
                        state_nxt = S_LOAD;
                    end
                end
                S_DONE: begin
                    state_nxt = S_IDLE;
                end
                default: begin
                    state_nxt = S_IDLE;
                    phase_nxt = '0;
                end
            endcase
        end
    end

    // State register and registered outputs.
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            phase      <= '0;
            tmr_secs   <= '0;
            tmr_load   <= 1'b0;
            tmr_clear  <= 1'b0;
            cycle_done <= 1'b0;
        end else begin
            state_q    <= state_nxt;
            phase      <= phase_nxt;
            tmr_secs   <= secs_nxt;
            tmr_load   <= load_nxt;
            tmr_clear  <= clear_nxt;
            cycle_done <= cdone_nxt;
        end
    end

`ifdef PHASE_SEQ_PAUSE_EN
    // Pause bookkeeping: hold request to the timer and a latched done.
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            tmr_hold  <= 1'b0;
            done_pend <= 1'b0;
        end else begin
            tmr_hold  <= hold_nxt;
            done_pend <= pend_nxt;
        end
    end
`endif

endmodule
